// File: rtl/adder_pipe_acc_if.sv
// Valid/ready bus for adder_pipe_acc. Lanes are packed side by side, with lane i at the low-order end for i=0.
// master drives the operands and out_ready; slave is the adder.
interface adder_pipe_acc_if #(
   parameter int unsigned WIDTH_A   = 4,
   parameter int unsigned WIDTH_B   = 8,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned LANES     = 2
);
   logic                         in_valid;
   logic                         in_ready;
   logic [LANES*WIDTH_A-1:0]     A;
   logic [LANES*WIDTH_B-1:0]     B;
   logic [LANES-1:0]             Carry;
   logic                         mode;
   logic                         acc_clear;
   logic                         out_valid;
   logic                         out_ready;
   logic [LANES*OUT_WIDTH-1:0]   OUT;
   logic [LANES-1:0]             ovf;

   modport master (
      output in_valid, A, B, Carry, mode, acc_clear, out_ready,
      input  in_ready, out_valid, OUT, ovf
   );

   modport slave (
      input  in_valid, A, B, Carry, mode, acc_clear, out_ready,
      output in_ready, out_valid, OUT, ovf
   );
endinterface

// File: rtl/adder_pipe_acc.sv
// Two-stage multi-lane signed adder (A+B+Carry) with an optional per-lane running accumulator.
// Define ADDER_PIPE_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module adder_pipe_acc #(
   parameter int unsigned WIDTH_A   = 4,
   parameter int unsigned WIDTH_B   = 8,
   parameter int unsigned OUT_WIDTH = 16,
   parameter int unsigned LANES     = 2
) (
   input logic             clk,
   input logic             rst_n,
   adder_pipe_acc_if.slave bus
);
   localparam int unsigned BITS = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
   localparam int unsigned SW   = BITS + 1;
   localparam int unsigned OW   = OUT_WIDTH;

`ifdef ADDER_PIPE_SAT_EN
   localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};
`endif

   logic                   s1_valid_q, s1_valid_d;
   logic [LANES-1:0][SW-1:0] s1_sum_q, s1_sum_d;
   logic                   s1_mode_q, s1_mode_d;
   logic                   s1_clr_q, s1_clr_d;

   logic                   out_valid_q, out_valid_d;
   logic [LANES-1:0][OW-1:0] out_q, out_d;
   logic [LANES-1:0]       ovf_q, ovf_d;
   logic [LANES-1:0][OW-1:0] acc_q, acc_d;

   logic                   s2_adv;
   logic                   s1_load;
   logic [SW-1:0]          a_ext, b_ext;
   logic [OW-1:0]          sum_ext, r_sum, res;
   logic                   lane_ovf;

   assign s2_adv       = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s2_adv;
   assign s1_load      = bus.in_valid && bus.in_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.OUT       = out_q;
   assign bus.ovf       = ovf_q;

   // S1: widen both operands by one bit so the three-way add cannot overflow
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sum_d   = s1_sum_q;
      s1_mode_d  = s1_mode_q;
      s1_clr_d   = s1_clr_q;
      a_ext      = '0;
      b_ext      = '0;
      if (s1_load) begin
         s1_valid_d = 1'b1;
         s1_mode_d  = bus.mode;
         s1_clr_d   = bus.acc_clear;
         for (int i = 0; i < LANES; i++) begin
            a_ext       = SW'($signed(bus.A[i*WIDTH_A +: WIDTH_A]));
            b_ext       = SW'($signed(bus.B[i*WIDTH_B +: WIDTH_B]));
            s1_sum_d[i] = a_ext + b_ext + SW'(bus.Carry[i]);
         end
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2: pass-through or accumulate; accumulator moves only when a beat leaves S1
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      ovf_d       = ovf_q;
      acc_d       = acc_q;
      sum_ext     = '0;
      r_sum       = '0;
      res         = '0;
      lane_ovf    = 1'b0;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            for (int i = 0; i < LANES; i++) begin
               sum_ext  = OW'($signed(s1_sum_q[i]));
               r_sum    = acc_q[i] + sum_ext;
               res      = sum_ext;
               lane_ovf = 1'b0;
               if (s1_mode_q) begin
                  if (!s1_clr_q) begin
                     res      = r_sum;
                     lane_ovf = (acc_q[i][OW-1] == sum_ext[OW-1]) &&
                                (r_sum[OW-1] != acc_q[i][OW-1]);
`ifdef ADDER_PIPE_SAT_EN
                     if (lane_ovf) begin
                        res = acc_q[i][OW-1] ? SAT_MIN : SAT_MAX;
                     end
`endif
                  end
                  acc_d[i] = res;
               end
               out_d[i] = res;
               ovf_d[i] = lane_ovf;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_mode_q   <= 1'b0;
         s1_clr_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= '0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sum_q    <= s1_sum_d;
         s1_mode_q   <= s1_mode_d;
         s1_clr_q    <= s1_clr_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
         acc_q       <= acc_d;
      end
   end
endmodule

// File: tb/tb_adder_pipe_acc.sv
// Directed bench for adder_pipe_acc: a 16-bit-output instance for most tests, and a 10-bit one for overflow.
// Expected overflow results follow ADDER_PIPE_SAT_EN when it is defined.
module tb_adder_pipe_acc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   adder_pipe_acc_if #(.OUT_WIDTH(16)) b16 ();
   adder_pipe_acc_if #(.OUT_WIDTH(10)) b10 ();

   adder_pipe_acc #(.OUT_WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   adder_pipe_acc #(.OUT_WIDTH(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));

   // Lane operands, control bits, expected lane results and the expected ovf vector {lane1,lane0}
   typedef struct {
      int a0; int b0; int c0;
      int a1; int b1; int c1;
      int mode; int clr;
      int e0; int e1; int ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input vec_t v, input logic valid);
      if (sel == 0) begin
         b16.in_valid  = valid;
         b16.A         = {4'(v.a1), 4'(v.a0)};
         b16.B         = {8'(v.b1), 8'(v.b0)};
         b16.Carry     = {1'(v.c1), 1'(v.c0)};
         b16.mode      = 1'(v.mode);
         b16.acc_clear = 1'(v.clr);
      end else begin
         b10.in_valid  = valid;
         b10.A         = {4'(v.a1), 4'(v.a0)};
         b10.B         = {8'(v.b1), 8'(v.b0)};
         b10.Carry     = {1'(v.c1), 1'(v.c0)};
         b10.mode      = 1'(v.mode);
         b10.acc_clear = 1'(v.clr);
      end
   endtask

   function automatic logic signed [63:0] out_lane(input int sel, input int ln);
      if (sel == 0) return 64'($signed(b16.OUT[ln*16 +: 16]));
      return 64'($signed(b10.OUT[ln*10 +: 10]));
   endfunction

   function automatic logic signed [63:0] ovalid(input int sel);
      return (sel == 0) ? 64'(b16.out_valid) : 64'(b10.out_valid);
   endfunction

   function automatic logic signed [63:0] ovf_of(input int sel);
      return (sel == 0) ? 64'(b16.ovf) : 64'(b10.ovf);
   endfunction

   task automatic check_beat(input int sel, input string tag, input vec_t e);
      check({tag, ".v"},   ovalid(sel), 1);
      check({tag, ".o0"},  out_lane(sel, 0), 64'(e.e0));
      check({tag, ".o1"},  out_lane(sel, 1), 64'(e.e1));
      check({tag, ".ovf"}, ovf_of(sel), 64'(e.ovf));
   endtask

   // Back-to-back beats with out_ready high; result of beat k appears two edges after it is offered
   task automatic run_stream(input int sel, input int first, input int n, input string tag);
      for (int k = 0; k <= n; k++) begin
         if (k < n) drive(sel, tbl[first+k], 1'b1);
         else       drive(sel, tbl[first], 1'b0);
         @(posedge clk);
         @(negedge clk);
         if (k == 0) check($sformatf("%s[0].lat", tag), ovalid(sel), 0);
         else        check_beat(sel, $sformatf("%s[%0d]", tag, k - 1), tbl[first+k-1]);
      end
   endtask

   initial begin
      #200000;
      nerr++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_n;
      int oidx;
      int bpb;
      int rb;
      logic take_in;
      logic take_out;

      // T1/T2: pass-through and operand extremes
      tbl.push_back('{5, 3, 0, -5, -7, 1, 0, 0, 8, -11, 0});
      tbl.push_back('{-8, -128, 0, 7, 127, 1, 0, 0, -136, 135, 0});
      // T3: accumulate four beats; lane1 runs its own negative sum
      tbl.push_back('{7, 100, 0, -3, -50, 1, 1, 1, 107, -52, 0});
      tbl.push_back('{7, 100, 0, -3, -50, 1, 1, 0, 214, -104, 0});
      tbl.push_back('{7, 100, 0, -3, -50, 1, 1, 0, 321, -156, 0});
      tbl.push_back('{7, 100, 0, -3, -50, 1, 1, 0, 428, -208, 0});
      // mode=0 ignores acc_clear and leaves the accumulators alone
      tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0});
      tbl.push_back('{0, 0, 1, 0, 0, 0, 1, 0, 429, -208, 0});
      // T4 (10-bit output): 134 per beat on lane0, -136 per beat on lane1
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 1, 134, -136, 0});
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 0, 268, -272, 0});
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 0, 402, -408, 0});
`ifdef ADDER_PIPE_SAT_EN
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 0, 511, -512, 3});
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 0, 511, -512, 3});
`else
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 0, -488, 480, 3});
      tbl.push_back('{7, 127, 0, -8, -128, 0, 1, 0, -354, 344, 0});
`endif
      // T5 backpressure: 11 and -17 per beat
      bpb = tbl.size();
      tbl.push_back('{1, 10, 0, 2, -20, 1, 1, 1, 11, -17, 0});
      tbl.push_back('{1, 10, 0, 2, -20, 1, 1, 0, 22, -34, 0});
      tbl.push_back('{1, 10, 0, 2, -20, 1, 1, 0, 33, -51, 0});
      tbl.push_back('{1, 10, 0, 2, -20, 1, 1, 0, 44, -68, 0});
      tbl.push_back('{1, 10, 0, 2, -20, 1, 1, 0, 55, -85, 0});
      tbl.push_back('{1, 10, 0, 2, -20, 1, 1, 0, 66, -102, 0});
      // T6: beat after reset accumulates from zero
      rb = tbl.size();
      tbl.push_back('{1, 1, 0, 0, 0, 1, 1, 0, 2, 1, 0});

      drive(0, tbl[0], 1'b0);
      drive(1, tbl[0], 1'b0);
      b16.out_ready = 1'b1;
      b10.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst.v",   ovalid(0), 0);
      check("rst.o0",  out_lane(0, 0), 0);
      check("rst.o1",  out_lane(0, 1), 0);
      check("rst.ovf", ovf_of(0), 0);
      rst_n = 1'b1;
      #1;
      check("rst.rdy", 64'(b16.in_ready), 1);
      @(negedge clk);

      run_stream(0, 0, 8, "pass_acc");
      run_stream(1, 8, 5, "wrap10");

      // Backpressure: out_ready low for the first four cycles
      acc_n = 0;
      oidx  = 0;
      for (int c = 0; c < 40 && oidx < 6; c++) begin
         b16.out_ready = (c >= 4);
         if (acc_n < 6) drive(0, tbl[bpb+acc_n], 1'b1);
         else           drive(0, tbl[bpb], 1'b0);
         #1;
         if (c == 2 || c == 3) check($sformatf("bp.rdy%0d", c), 64'(b16.in_ready), 0);
         if (c == 4) check("bp.accepted", 64'(acc_n), 2);
         if (b16.out_valid) check_beat(0, $sformatf("bp[%0d]c%0d", oidx, c), tbl[bpb+oidx]);
         take_in  = b16.in_valid && b16.in_ready;
         take_out = b16.out_valid && b16.out_ready;
         @(posedge clk);
         if (take_in)  acc_n++;
         if (take_out) oidx++;
         @(negedge clk);
      end
      check("bp.count", 64'(oidx), 6);

      // Reset with two accumulating beats in flight
      drive(0, tbl[bpb+1], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, tbl[bpb+1], 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, tbl[bpb+1], 1'b0);
      check("mid.v", ovalid(0), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst.v",   ovalid(0), 0);
      check("mid_rst.o0",  out_lane(0, 0), 0);
      check("mid_rst.o1",  out_lane(0, 1), 0);
      check("mid_rst.ovf", ovf_of(0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst.v", ovalid(0), 0);
      run_stream(0, rb, 1, "post_rst");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
